// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle between packet producers, the round-robin arbiter and the async FIFO write port.
// The slave modport is the arbiter's view; master is the producer/FIFO side.
interface fifo_wr_arb_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            s_valid;
   logic [NUM_REQ-1:0]            s_last;
   logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
   logic [NUM_REQ-1:0]            s_ready;
   logic                          fifo_wen;
   logic [DATA_WIDTH-1:0]         fifo_din;
   logic                          full;
   logic [ID_W-1:0]               gnt_id;
   logic                          busy;

   modport master (
      output s_valid, s_last, s_data, full,
      input  s_ready, fifo_wen, fifo_din, gnt_id, busy
   );

   modport slave (
      input  s_valid, s_last, s_data, full,
      output s_ready, fifo_wen, fifo_din, gnt_id, busy
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ packet producers.
// A grant lasts until the owner's last beat or MAX_BURST beats, whichever comes first.
module fifo_wr_arb #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 16
) (
   input logic          wr_clk,
   input logic          wr_rst,
   fifo_wr_arb_if.slave bus
);
   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   typedef enum logic {StIdle, StHold} state_e;

   state_e           state_q, state_d;
   logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [ID_W-1:0]  pick;
   logic             found;
   int unsigned      rr_idx;
   logic             beat;
   logic             release_now;

   // First valid requester at or above rr_ptr, wrapping at NUM_REQ (need not be a power of two).
   always_comb begin
      pick   = '0;
      found  = 1'b0;
      rr_idx = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         rr_idx = 32'(rr_ptr_q) + i;
         if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
         if (!found && bus.s_valid[rr_idx[ID_W-1:0]]) begin
            found = 1'b1;
            pick  = rr_idx[ID_W-1:0];
         end
      end
   end

   assign beat        = (state_q == StHold) && bus.s_valid[gnt_id_q] && !bus.full;
   assign release_now = beat && (bus.s_last[gnt_id_q] || (beat_cnt_q == LAST_BEAT));

   always_comb begin
      state_d    = state_q;
      gnt_id_d   = gnt_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               gnt_id_d   = pick;
               beat_cnt_d = '0;
               state_d    = StHold;
            end
         end
         StHold: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (release_now) begin
                  rr_ptr_d = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
                  state_d  = StIdle;
               end
            end
         end
      endcase
   end

   // full gates ready combinationally so a write can never slip past it.
   always_comb begin
      bus.s_ready = '0;
      if (state_q == StHold) bus.s_ready[gnt_id_q] = !bus.full;
   end

   assign bus.fifo_wen = beat;
   assign bus.fifo_din = bus.s_data[32'(gnt_id_q) * DATA_WIDTH +: DATA_WIDTH];
   assign bus.gnt_id   = gnt_id_q;
   assign bus.busy     = (state_q == StHold);

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state_q    <= StIdle;
         gnt_id_q   <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_id_q   <= gnt_id_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Write-side round-robin arbiter that shares the single write port of the asynchronous FIFO (`fifo_a`) among `NUM_REQ` packet producers in the write clock domain. Each producer offers beats with a valid/ready/last handshake. The arbiter locks the FIFO write port to one producer per packet, bounded by `MAX_BURST` beats. It back-pressures every producer from the FIFO `full` flag, so no write is ever issued while the FIFO is full.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16, need not be a power of two.
- `DATA_WIDTH`, 32: beat width; matches the FIFO `DATA_WIDTH`.
- `MAX_BURST`, 16: maximum beats per grant, ≥1.
- `ID_W`, derived: `$clog2(NUM_REQ)`, not overridden.

Ports:
- `wr_clk`  in  1  single clock, rising edge; the FIFO write clock.
- `wr_rst`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  NUM_REQ  per-requester beat valid.
- `s_last`  in  NUM_REQ  per-requester last beat of packet; qualified by valid.
- `s_data`  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_ready`  out  NUM_REQ  per-requester ready; at most one bit high.
- `fifo_wen`  out  1  to FIFO `wen`.
- `fifo_din`  out  DATA_WIDTH  to FIFO `din`.
- `full`  in  1  from FIFO `full`.
- `gnt_id`  out  ID_W  current or most recent grant owner.
- `busy`  out  1  high while a grant is held.

## Operation
State machine with two states, IDLE and HOLD. Registered state: `state`, `gnt_id`, `rr_ptr`, `beat_cnt` (`$clog2(MAX_BURST)` bits, minimum 1).

- **IDLE**
  - All `s_ready` are 0.
  - If any `s_valid` is high, grant the first requester with valid high, searching upward from `rr_ptr` and wrapping from `NUM_REQ-1` to 0.
  - Register the winner in `gnt_id`, clear `beat_cnt`, and go to HOLD.
  - If no `s_valid` is high, stay in IDLE.
- **HOLD**
  - `s_ready[gnt_id] = !full`; all other ready bits are 0.
  - A beat is transferred when `s_valid[gnt_id] && s_ready[gnt_id]`.
  - `fifo_wen` equals the beat strobe (combinational).
  - `fifo_din = s_data` slice `gnt_id` at all times.
  - Each beat increments `beat_cnt`.
  - **Release:** on a beat with `s_last[gnt_id]`, or on the beat where `beat_cnt == MAX_BURST-1`, do all of the following:
    - set `rr_ptr = (gnt_id+1) mod NUM_REQ`;
    - go to IDLE;
    - leave `gnt_id` holding its value.
  - If the owner drops `s_valid` mid-packet, the grant is held indefinitely. There is no timeout.
  - While `full` is high, ready stays low, no write is issued, and the grant and `beat_cnt` are held.
- A packet truncated by `MAX_BURST` continues as a new grant later; the arbiter inserts no markers.
- `busy` = (state == HOLD).
- **Reset (asynchronous, any time, including mid-packet):**
  - `state` = IDLE, `gnt_id` = 0, `rr_ptr` = 0, `beat_cnt` = 0.
  - Resulting outputs: `s_ready` = 0, `fifo_wen` = 0, `busy` = 0, `fifo_din` = slice 0.
  - A partial packet already written to the FIFO remains there; recovering from it is the owner's responsibility.

## Timing
- **Grant latency:** valid first seen in IDLE at cycle k → HOLD and `gnt_id` valid from cycle k+1. The first beat can transfer in cycle k+1 if `full` is low.
- **Throughput:** one beat per cycle in HOLD while valid is high and full is low.
- **Release bubble:** last beat in cycle m → IDLE in cycle m+1 (no transfer) → the next grant's first beat no earlier than cycle m+2.
- **Back-pressure:** `full` to `s_ready`/`fifo_wen` is same-cycle combinational, so no registered write can slip past `full`.
- **Simultaneous events:**
  - Last beat and `MAX_BURST` limit on the same beat → a single release.
  - `full` rising in the same cycle as the owner's valid → no beat that cycle.
- `s_data`, `s_last` and `full` must be stable around the `wr_clk` rising edge. There is no internal synchronization.

## Test plan
1. **Reset:** assert `wr_rst` with all `s_valid` high.
   - Required: `s_ready` = 0, `fifo_wen` = 0, `busy` = 0, `gnt_id` = 0 immediately, without a clock edge.
2. **Single packet:** requester 1 sends 3 beats 0xA0, 0xA1, 0xA2, with last on the third; `full` low.
   - Required: `gnt_id` = 1 the cycle after valid.
   - Required: three consecutive `fifo_wen` pulses with `fifo_din` 0xA0, 0xA1, 0xA2.
   - Required: `busy` low the cycle after 0xA2.
3. **Round-robin fairness:** all 4 requesters hold continuous single-beat packets, data = id.
   - Required: FIFO receives 0,1,2,3,0,1,... with one beat every 2 cycles.
4. **Burst limit:** requester 2 sends 40 beats without last while requester 3 is pending; `MAX_BURST` = 16.
   - Required: 16 beats from requester 2, then requester 3's packet, then requester 2 resumes at beat 17.
5. **Full stall:** `full` is high for 5 cycles during beat 4 of a 10-beat packet.
   - Required: `s_ready` and `fifo_wen` are low for those 5 cycles and the grant is held.
   - Required: all 10 beats are written in order with no loss or duplication.
6. **Reset mid-packet:** `wr_rst` is pulsed after beat 2 of requester 3's packet, while requesters 0 and 3 are both valid.
   - Required: immediate reset values.
   - Required: after release, requester 0 is granted first because `rr_ptr` is 0.
